// File: rtl/uart_pkg.sv
// Shared types for the UART TX arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Default per-grant byte limit when the burst limit is compiled in.
  localparam int DEF_MAX_BURST = 32;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin first-set-bit finder: returns the first set bit of req after ptr.
// Latency: purely combinational.
// Backpressure: none; found=0 when req is all zero.
//
// Ports:
//   req   in  WIDTH  request vector
//   ptr   in  IDX_W  last winner; the scan starts at ptr+1 and wraps
//   idx   out IDX_W  winning index (0 when nothing is found)
//   found out 1      any bit of req is set
module rr_pick #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Walk from the farthest offset to the nearest so that the nearest set
    // bit after ptr is the last one written and therefore wins. Offset WIDTH
    // is ptr itself, i.e. the previous winner comes last in priority.
    for (int off = WIDTH; off >= 1; off--) begin
      cand = IDX_W'((int'(ptr) + off) % WIDTH);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte TX port between NUM_REQ requesters, round-robin per message.
// Latency: 1 arbitration cycle from IDLE; bytes then pass combinationally with no buffering.
// Backpressure: tx_data_ack is routed straight to req_ack of the owner; all others see 0.
//
// Ports:
//   clk, rst_n                         clock and asynchronous active-low reset
//   req_data/req_valid/req_last/req_ack per-requester byte channel (byte i at [8i+7:8i])
//   tx_data/tx_data_valid/tx_data_ack   byte channel to the UART
//   grant_id, busy                      current owner (valid while busy), grant held
//
// Optional: define UART_TX_ARB_BURST_LIMIT_EN to release a grant after
// MAX_BURST bytes even without a last flag.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ack,
  output uart_byte_t                 tx_data,
  output logic                       tx_data_valid,
  input  logic                       tx_data_ack,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int GW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_param
    $error("uart_tx_arbiter: NUM_REQ or MAX_BURST out of range");
  end

  arb_state_e    state_q, state_d;
  logic [GW-1:0] rr_ptr_q;
  logic [GW-1:0] grant_id_q;
  logic [GW-1:0] pick_idx;
  logic          pick_found;
  logic          xfer;
  logic          burst_hit;
  logic          release_grant;

  rr_pick #(
    .WIDTH (NUM_REQ),
    .IDX_W (GW)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // A byte moves only while we own the UART and both sides agree.
  assign xfer = (state_q == ARB_GRANT) && req_valid[grant_id_q] && tx_data_ack;

`ifdef UART_TX_ARB_BURST_LIMIT_EN
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  logic [7:0] burst_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (state_q == ARB_IDLE && pick_found) begin
      burst_cnt <= '0;
    end else if (xfer) begin
      burst_cnt <= burst_cnt + 8'd1;
    end
  end

  // Count before this transfer is MAX_BURST-1, so this transfer reaches the limit.
  assign burst_hit = (burst_cnt == BURST_LAST);
`else
  assign burst_hit = 1'b0;
`endif

  assign release_grant = xfer && (req_last[grant_id_q] || burst_hit);

  // State register plus the registered arbitration bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= GW'(NUM_REQ - 1);
      grant_id_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_IDLE && pick_found) begin
        grant_id_q <= pick_idx;
      end
      if (release_grant) begin
        rr_ptr_q <= grant_id_q;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (pick_found)    state_d = ARB_GRANT;
      ARB_GRANT: if (release_grant) state_d = ARB_IDLE;
      default:                      state_d = ARB_IDLE;
    endcase
  end

  // Output logic: a straight mux from the owner to the UART while granted.
  always_comb begin
    tx_data       = '0;
    tx_data_valid = 1'b0;
    req_ack       = '0;
    if (state_q == ARB_GRANT) begin
      tx_data             = req_data[{grant_id_q, 3'b000} +: 8];
      tx_data_valid       = req_valid[grant_id_q];
      req_ack[grant_id_q] = tx_data_ack;
    end
  end

  assign busy     = (state_q == ARB_GRANT);
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed messages per requester, expected
// (owner, byte) pairs queued by the stimulus and popped by a monitor on each UART transfer.
// Define UART_TX_ARB_BURST_LIMIT_EN to also run the burst-limit scenario.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;
  localparam int GW        = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ*8-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ack;
  logic [7:0]           tx_data;
  logic                 tx_data_valid;
  logic                 tx_data_ack = 1'b0;
  logic [GW-1:0]        grant_id;
  logic                 busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_ack       (req_ack),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ack   (tx_data_ack),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  typedef struct packed { logic [7:0] dat; logic last; } beat_t;
  typedef struct packed { logic [1:0] id; logic [7:0] dat; } exp_t;

  beat_t              drv_q[NUM_REQ][$];
  exp_t               sb_q[$];
  int                 xfer_cycle[$];
  exp_t               mon_e;
  logic [NUM_REQ-1:0] took = '0;
  int                 ack_period = 1;
  int                 ack_cnt = 0;
  int                 cycle = 0;
  int                 stall_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input int r, input logic [7:0] dat, input logic last);
    beat_t b;
    b.dat  = dat;
    b.last = last;
    drv_q[r].push_back(b);
  endtask

  task automatic expect_byte(input int id, input logic [7:0] dat);
    exp_t e;
    e.id  = 2'(id);
    e.dat = dat;
    sb_q.push_back(e);
  endtask

  task automatic flush_all();
    for (int r = 0; r < NUM_REQ; r++) drv_q[r].delete();
    sb_q.delete();
    xfer_cycle.delete();
  endtask

  // Waits (bounded) until every expected byte has been seen; polls at posedge+2.
  task automatic wait_sb(input string name, input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d bytes still expected after %0d cycles", name, sb_q.size(), budget);
      sb_q.delete();
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    cycle++;
    took = req_valid & req_ack;
    if (tx_data_valid && tx_data_ack) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got id %0d data %02h, expected no transfer", grant_id, tx_data);
      end else begin
        mon_e = sb_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(mon_e.dat));
        check("grant_id", 32'(grant_id), 32'(mon_e.id));
        check("req_ack", 32'(req_ack), 32'(1) << mon_e.id);
        xfer_cycle.push_back(cycle);
      end
    end
  end

  // Requester and UART models: update at posedge+1 from what the monitor saw.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (took[r] && drv_q[r].size() > 0) drv_q[r].delete(0);
        if (drv_q[r].size() > 0) begin
          req_valid[r]        = 1'b1;
          req_data[r*8 +: 8]  = drv_q[r][0].dat;
          req_last[r]         = drv_q[r][0].last;
        end else begin
          req_valid[r]        = 1'b0;
          req_data[r*8 +: 8]  = 8'h00;
          req_last[r]         = 1'b0;
        end
      end
      ack_cnt     = (ack_cnt + 1) % ack_period;
      tx_data_ack = (ack_cnt == 0);
    end
  end

  initial begin
    // Reset state, with requester 1 already presenting its message.
    rst_n      = 1'b0;
    ack_period = 80;
    drv(1, 8'h41, 1'b0);
    drv(1, 8'h42, 1'b0);
    drv(1, 8'h43, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_valid", 32'(tx_data_valid), 32'd0);
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);

    // Single requester, slow UART.
    expect_byte(1, 8'h41);
    expect_byte(1, 8'h42);
    expect_byte(1, 8'h43);
    rst_n = 1'b1;
    wait_sb("single", 400);
    check("single_busy_drop", 32'(busy), 32'd0);

    // Contention out of reset: req 0 then req 2, one idle cycle between.
    rst_n      = 1'b0;
    ack_period = 1;
    flush_all();
    drv(0, 8'hA0, 1'b0);
    drv(0, 8'hA1, 1'b1);
    drv(2, 8'hB0, 1'b0);
    drv(2, 8'hB1, 1'b1);
    expect_byte(0, 8'hA0);
    expect_byte(0, 8'hA1);
    expect_byte(2, 8'hB0);
    expect_byte(2, 8'hB1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    wait_sb("contention", 50);
    check("contention_b2b", 32'(xfer_cycle[1] - xfer_cycle[0]), 32'd1);
    check("contention_gap", 32'(xfer_cycle[2] - xfer_cycle[1]), 32'd2);

    // Round-robin rotation with single-byte messages.
    rst_n = 1'b0;
    flush_all();
    drv(0, 8'hC0, 1'b1);
    drv(0, 8'hC4, 1'b1);
    drv(1, 8'hC1, 1'b1);
    drv(2, 8'hC2, 1'b1);
    drv(3, 8'hC3, 1'b1);
    expect_byte(0, 8'hC0);
    expect_byte(1, 8'hC1);
    expect_byte(2, 8'hC2);
    expect_byte(3, 8'hC3);
    expect_byte(0, 8'hC4);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    wait_sb("rotation", 60);

    // Stall mid-message: req 3 goes quiet, req 0 waits, ack stays high.
    drv(3, 8'hD0, 1'b0);
    expect_byte(3, 8'hD0);
    wait_sb("stall_first", 20);
    drv(0, 8'hE0, 1'b1);
    stall_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (!(busy && grant_id == 2'd3 && !tx_data_valid && req_ack[0] == 1'b0)) stall_bad++;
    end
    check("stall_hold_bad_cycles", 32'(stall_bad), 32'd0);
    drv(3, 8'hD1, 1'b1);
    expect_byte(3, 8'hD1);
    expect_byte(0, 8'hE0);
    wait_sb("stall_resume", 20);

    // Asynchronous reset between bytes of a message.
    ack_period = 4;
    drv(1, 8'hF0, 1'b0);
    drv(1, 8'hF1, 1'b0);
    drv(1, 8'hF2, 1'b1);
    expect_byte(1, 8'hF0);
    wait_sb("areset_first", 40);
    check("areset_busy_before", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_req_ack", 32'(req_ack), 32'd0);
    check("areset_tx_valid", 32'(tx_data_valid), 32'd0);
    flush_all();
    ack_period = 1;
    drv(2, 8'h62, 1'b1);
    drv(1, 8'h61, 1'b1);
    expect_byte(1, 8'h61);
    expect_byte(2, 8'h62);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    wait_sb("areset_regrant", 30);

`ifdef UART_TX_ARB_BURST_LIMIT_EN
    // Burst limit of 4: req 0's long message is split around req 1's message.
    rst_n = 1'b0;
    flush_all();
    for (int b = 0; b < 10; b++) drv(0, 8'(b), (b == 9));
    drv(1, 8'h10, 1'b0);
    drv(1, 8'h11, 1'b1);
    for (int b = 0; b < 4; b++) expect_byte(0, 8'(b));
    expect_byte(1, 8'h10);
    expect_byte(1, 8'h11);
    for (int b = 4; b < 10; b++) expect_byte(0, 8'(b));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    wait_sb("burst", 100);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single byte-level TX interface of the UART block (tx_data / tx_data_valid / tx_data_ack) between NUM_REQ independent requesters, e.g. debug console, command responder and log streamer.
- Arbitration is round-robin at message granularity. A granted requester keeps the UART until it sends a byte flagged last, so messages are never interleaved on the wire.
- Sits between the requesters and the UART instance, in the same clock domain.

Parameters:
- NUM_REQ, 4: number of requesters. Legal range 2..16.
- MAX_BURST, 32: byte limit per grant. Used only when the optional feature is compiled in. Legal range 1..255.

Ports:
- clk  in  1  system clock, same clock as the UART.
- rst_n  in  1  asynchronous active-low reset.
- req_data  in  NUM_REQ*8  per-requester byte. Requester i uses bits [8i+7:8i].
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_last  in  NUM_REQ  byte is the final byte of its message.
- req_ack  out  NUM_REQ  per-requester accept. A byte transfers when req_valid[i] & req_ack[i].
- tx_data  out  8  byte to the UART.
- tx_data_valid  out  1  to the UART.
- tx_data_ack  in  1  from the UART. High means the UART accepts a byte this cycle if valid is high.
- grant_id  out  $clog2(NUM_REQ)  current owner. Meaningful only while busy.
- busy  out  1  a grant is held.

Behaviour:
- Reset values (asynchronous, while rst_n is low): state=IDLE, rr_ptr=NUM_REQ-1, grant_id=0, busy=0, tx_data_valid=0, tx_data=0, req_ack=0, burst_cnt=0.
- FSM state IDLE:
  - All req_ack and tx_data_valid are 0.
  - If any req_valid is set, select the first set bit scanning rr_ptr+1, rr_ptr+2, … modulo NUM_REQ, latch it into grant_id, and go to GRANT.
  - Arbitration costs exactly 1 cycle. The first byte can transfer no earlier than the cycle after the request is seen.
- FSM state GRANT (g = grant_id):
  - tx_data = req_data[g], tx_data_valid = req_valid[g], req_ack[g] = tx_data_ack. All other req_ack bits are 0.
  - These outputs are combinational from registered state and the inputs. No added latency, no buffering.
  - A byte transfers when req_valid[g] & tx_data_ack.
  - If req_last[g] is set on the transfer: go to IDLE and set rr_ptr=g.
- Back-to-back messages: after a last byte there is always one IDLE cycle before the next grant, including a re-grant to the same requester.
- Requester drops valid mid-message: the grant is held and tx_data_valid=0. There is no timeout in the base build.
- Other requesters asserting valid while a grant is held see req_ack=0 and must hold data stable (standard valid/ack rules). Requesters must not deassert valid before ack.
- Fairness: if requesters 0 and 2 both request with rr_ptr=0, requester 2 wins, then requester 0.
- tx_data_ack high with tx_data_valid low: no state change.
- Reset asserted mid-message: returns to IDLE immediately. Any partially sent message is truncated on the UART side, with no recovery.

Optional Feature:
- Macro: UART_TX_ARB_BURST_LIMIT_EN.
- When defined:
  - An 8-bit burst_cnt clears on grant and increments per transferred byte.
  - When a transfer makes burst_cnt equal MAX_BURST without req_last, the grant is released as if last had been seen (go to IDLE, rr_ptr=g). This bounds latency for other requesters; long messages may then be interleaved at MAX_BURST-byte boundaries.
  - A transfer with last always releases, whatever the count.
- When undefined: no counter exists and only req_last releases the grant.

Decomposition:
- Package uart_pkg:
  - typedef uart_byte_t (logic [7:0]).
  - enum arb_state_e {ARB_IDLE, ARB_GRANT}.
  - localparam default MAX_BURST.
- One sub-module, rr_pick: a combinational round-robin first-set-bit finder with inputs req vector and pointer, outputs index and found. Parameterised by width and reusable by other arbiters.

Test Plan:
- Single requester: req 1 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43), UART ack every 80 clocks → tx_data sequence 41,42,43; grant_id=1; busy drops 1 cycle after the 0x43 transfer.
- Contention: reqs 0 and 2 valid at reset-exit, each sending a 2-byte message → order is req0 msg, then req2 msg, with no interleave and 1 IDLE cycle between.
- Round-robin rotation: all 4 requesters continuously valid with 1-byte messages → grant order 0,1,2,3,0.
- Stall mid-message: req 3 drops valid for 50 cycles after its first byte while req 0 is valid → grant stays 3 and tx_data_valid=0; req 0 is granted only after req 3's last byte.
- Async reset mid-message: pull rst_n low between bytes → busy=0 and req_ack=0 without waiting for clk; next grant after release goes to the lowest valid index from rr_ptr=NUM_REQ-1.
- Burst limit (macro defined, MAX_BURST=4): req 0 sends a 10-byte message while req 1 is valid → bytes 0..3 from req 0, then req 1's message, then req 0 resumes.
